// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  localparam int DIV_DW = 24;
  localparam int DIV_VW = 8;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_WORK = 1'b1
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, then subtract
// the divisor if the partial remainder can absorb it.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] rem_i,
  input  logic          dq_msb_i,
  input  logic [VW-1:0] dv_i,
  output logic [VW-1:0] rem_o,
  output logic          q_o
);

  logic [VW:0] w_t;

  // The trial value needs VW+1 bits. The kept remainder is always below a
  // non-zero divisor. With a zero divisor, bit VW is shifted out on the next
  // step and never read, so VW bits are enough.
  assign w_t   = {rem_i, dq_msb_i};
  assign q_o   = (w_t >= {1'b0, dv_i});
  assign rem_o = q_o ? VW'(w_t - {1'b0, dv_i}) : w_t[VW-1:0];

endmodule

// File: rtl/div_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_EARLY_ZERO_EN: a zero divisor completes at the accepting edge.
module div_seq
  import div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] a_bi,
  input  logic [VW-1:0] b_bi,
  input  logic          start_i,
  output logic          busy_o,
  output logic [DW-1:0] q_bo,
  output logic [VW-1:0] r_bo,
  output logic          dz_o
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  div_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_ctr,   w_ctr_nxt;
  logic [DW-1:0] r_dq,    w_dq_nxt;
  logic [VW-1:0] r_dv,    w_dv_nxt;
  logic [VW-1:0] r_rem,   w_rem_nxt;
  logic [DW-1:0] r_q,     w_q_nxt;
  logic [VW-1:0] r_r,     w_r_nxt;
  logic          r_dz,    w_dz_nxt;

  logic [VW-1:0] w_step_rem;
  logic          w_step_q;
  logic          w_early_zero;

  div_step #(.VW(VW)) u_step (
    .rem_i    (r_rem),
    .dq_msb_i (r_dq[DW-1]),
    .dv_i     (r_dv),
    .rem_o    (w_step_rem),
    .q_o      (w_step_q)
  );

`ifdef DIV_EARLY_ZERO_EN
  assign w_early_zero = (b_bi == {VW{1'b0}});
`else
  assign w_early_zero = 1'b0;
`endif

  assign busy_o = (r_state == DIV_WORK) | start_i;
  assign q_bo   = r_q;
  assign r_bo   = r_r;
  assign dz_o   = r_dz;

  // Next-state, datapath and result-register update
  always_comb begin
    w_state_nxt = r_state;
    w_ctr_nxt   = r_ctr;
    w_dq_nxt    = r_dq;
    w_dv_nxt    = r_dv;
    w_rem_nxt   = r_rem;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_dz_nxt    = r_dz;
    case (r_state)
      DIV_IDLE: begin
        if (start_i && w_early_zero) begin
          w_q_nxt  = {DW{1'b1}};
          w_r_nxt  = a_bi[VW-1:0];
          w_dz_nxt = 1'b1;
        end else if (start_i) begin
          w_dq_nxt    = a_bi;
          w_dv_nxt    = b_bi;
          w_rem_nxt   = {VW{1'b0}};
          w_ctr_nxt   = {CW{1'b0}};
          w_state_nxt = DIV_WORK;
        end else begin
          w_state_nxt = DIV_IDLE;
        end
      end
      DIV_WORK: begin
        w_dq_nxt  = {r_dq[DW-2:0], w_step_q};
        w_rem_nxt = w_step_rem;
        w_ctr_nxt = r_ctr + CW'(1);
        if (r_ctr == LAST) begin
          w_q_nxt     = {r_dq[DW-2:0], w_step_q};
          w_r_nxt     = w_step_rem;
          w_dz_nxt    = (r_dv == {VW{1'b0}});
          w_state_nxt = DIV_IDLE;
        end else begin
          w_state_nxt = DIV_WORK;
        end
      end
      default: begin
        w_state_nxt = DIV_IDLE;
      end
    endcase
  end

  // State, working registers and result registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= DIV_IDLE;
      r_ctr   <= {CW{1'b0}};
      r_dq    <= {DW{1'b0}};
      r_dv    <= {VW{1'b0}};
      r_rem   <= {VW{1'b0}};
      r_q     <= {DW{1'b0}};
      r_r     <= {VW{1'b0}};
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ctr   <= w_ctr_nxt;
      r_dq    <= w_dq_nxt;
      r_dv    <= w_dv_nxt;
      r_rem   <= w_rem_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq with hand-computed expected values.
module tb_div_seq;

  logic        clk_i;
  logic        rst_i;
  logic [23:0] a_bi;
  logic [7:0]  b_bi;
  logic        start_i;
  logic        busy_o;
  logic [23:0] q_bo;
  logic [7:0]  r_bo;
  logic        dz_o;

  int tests_run;
  int tests_failed;

`ifdef DIV_EARLY_ZERO_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 24;
`endif

  div_seq #(.DW(24), .VW(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_bi    (a_bi),
    .b_bi    (b_bi),
    .start_i (start_i),
    .busy_o  (busy_o),
    .q_bo    (q_bo),
    .r_bo    (r_bo),
    .dz_o    (dz_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // inj: step count at which a stray start is pulsed; rst_at: step count for a reset abort
  task automatic run_op(input string tag, input logic [23:0] a, input logic [7:0] b,
                        input int inj, input int rst_at,
                        input logic [23:0] eq, input logic [7:0] er, input logic edz,
                        input int elat);
    int n;
    bit aborted;
    @(negedge clk_i);
    a_bi = a;
    b_bi = b;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    n = 0;
    aborted = 1'b0;
    while (busy_o && n < 100 && !aborted) begin
      @(posedge clk_i);
      #1;
      n++;
      if (start_i) start_i = 1'b0;
      if (n == inj) begin
        a_bi = 24'd50;
        b_bi = 8'd5;
        start_i = 1'b1;
        check_eq({tag, "_busy_inj"}, 32'(busy_o), 32'd1);
      end
      if (n == rst_at) begin
        rst_i = 1'b1;
        #1;
        check_eq({tag, "_rst_q"}, 32'(q_bo), 32'd0);
        check_eq({tag, "_rst_r"}, 32'(r_bo), 32'd0);
        check_eq({tag, "_rst_dz"}, 32'(dz_o), 32'd0);
        check_eq({tag, "_rst_busy"}, 32'(busy_o), 32'd0);
        #1;
        rst_i = 1'b0;
        aborted = 1'b1;
      end
    end
    if (!aborted) begin
      check_eq({tag, "_lat"}, 32'(n), 32'(elat));
      check_eq({tag, "_q"}, 32'(q_bo), 32'(eq));
      check_eq({tag, "_r"}, 32'(r_bo), 32'(er));
      check_eq({tag, "_dz"}, 32'(dz_o), 32'(edz));
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_i = 1'b0;
    start_i = 1'b0;
    a_bi = 24'd0;
    b_bi = 8'd0;

    // Asynchronous reset between edges
    #2 rst_i = 1'b1;
    #1;
    check_eq("rst_q", 32'(q_bo), 32'd0);
    check_eq("rst_r", 32'(r_bo), 32'd0);
    check_eq("rst_dz", 32'(dz_o), 32'd0);
    check_eq("rst_busy0", 32'(busy_o), 32'd0);
    start_i = 1'b1;
    #1;
    check_eq("rst_busy1", 32'(busy_o), 32'd1);
    start_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

    run_op("basic",  24'd1000,     8'd7,   -1, -1, 24'd142,      8'd6,   1'b0, 24);
    run_op("max_d1", 24'hFFFFFF,   8'd1,   -1, -1, 24'hFFFFFF,   8'd0,   1'b0, 24);
    run_op("small",  24'd5,        8'd255, -1, -1, 24'd0,        8'd5,   1'b0, 24);
    run_op("divz",   24'h123456,   8'd0,   -1, -1, 24'hFFFFFF,   8'h56,  1'b1, ZERO_LAT);

    // Outputs are not cleared by a new start
    @(negedge clk_i);
    a_bi = 24'd200;
    b_bi = 8'd3;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    check_eq("hold_dz", 32'(dz_o), 32'd1);
    check_eq("hold_q", 32'(q_bo), 32'hFFFFFF);
    repeat (30) @(posedge clk_i);

    run_op("stray",  24'd200,      8'd3,   10, -1, 24'd66,       8'd2,   1'b0, 24);
    run_op("abort",  24'd1000,     8'd7,   -1, 12, 24'd0,        8'd0,   1'b0, 0);
    run_op("after",  24'd100,      8'd9,   -1, -1, 24'd11,       8'd1,   1'b0, 24);

    // Back-to-back with start held: next op accepted on the edge after completion
    @(negedge clk_i);
    a_bi = 24'd1000;
    b_bi = 8'd7;
    start_i = 1'b1;
    @(posedge clk_i);
    repeat (24) @(posedge clk_i);
    #1;
    check_eq("b2b_q1", 32'(q_bo), 32'd142);
    check_eq("b2b_r1", 32'(r_bo), 32'd6);
    a_bi = 24'd100;
    b_bi = 8'd9;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    check_eq("b2b_busy", 32'(busy_o), 32'd1);
    begin
      int n;
      n = 0;
      while (busy_o && n < 100) begin
        @(posedge clk_i);
        #1;
        n++;
      end
      check_eq("b2b_lat", 32'(n), 32'd24);
      check_eq("b2b_q2", 32'(q_bo), 32'd11);
      check_eq("b2b_r2", 32'(r_bo), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
